// File: rtl/regfile_multiport.sv
// Parameterised multi-read-port register file with registered reads and a hardware clear sequencer.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_multiport #(
    parameter int WORDSIZE = 64,
    parameter int SIZE     = 32,
    parameter int NREAD    = 2,
    parameter int ADDR_W   = $clog2(SIZE)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREAD*ADDR_W-1:0]   rs_addr,
    output logic [NREAD*WORDSIZE-1:0] rs_out,
    input  logic [ADDR_W-1:0]         rd_addr,
    input  logic [WORDSIZE-1:0]       rd_in,
    input  logic                      we,
    input  logic                      clear_req,
    output logic                      busy,
    input  logic [ADDR_W-1:0]         debug_addr,
    output logic [WORDSIZE-1:0]       debug_out
);
    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [ADDR_W:0] SIZE_C = (ADDR_W+1)'(SIZE);
    localparam logic [ADDR_W:0] LAST_C = (ADDR_W+1)'(SIZE - 1);

    state_t              state, state_n;
    logic [ADDR_W:0]     clr_cnt, clr_cnt_n;
    logic                clr_we;
    logic                wr_ok;
    logic [WORDSIZE-1:0] mem [SIZE];
    logic [WORDSIZE-1:0] dbg_d;

    function automatic logic valid_addr(input logic [ADDR_W-1:0] a);
        return (a != '0) && ({1'b0, a} < SIZE_C);
    endfunction

    // Zero register, out-of-range addresses and the clear window all read as 0.
    function automatic logic [WORDSIZE-1:0] rd_word(input logic [ADDR_W-1:0] a);
        logic [WORDSIZE-1:0] v;
        v = '0;
        if (!busy && valid_addr(a)) begin
            v = mem[a];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && rd_addr == a) v = rd_in;
`endif
        end
        return v;
    endfunction

    assign busy  = (state == CLEAR);
    // A simultaneous clear request takes priority and drops the write.
    assign wr_ok = (state == IDLE) && we && !clear_req && valid_addr(rd_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_n;
            clr_cnt <= clr_cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        clr_cnt_n = clr_cnt;
        clr_we    = 1'b0;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_n   = CLEAR;
                    clr_cnt_n = '0;
                end
            end
            CLEAR: begin
                clr_we    = 1'b1;
                clr_cnt_n = clr_cnt + 1'b1;
                if (clr_cnt == LAST_C) state_n = IDLE;
            end
            default: state_n = CLEAR;
        endcase
    end

    // Storage has no reset; the sequencer zeroes it after every reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we)     mem[clr_cnt[ADDR_W-1:0]] <= '0;
            else if (wr_ok) mem[rd_addr]             <= rd_in;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [ADDR_W-1:0]   a;
        logic [WORDSIZE-1:0] d, q;

        assign a = rs_addr[k*ADDR_W +: ADDR_W];
        assign d = rd_word(a);

        always_ff @(posedge clk) begin
            if (rst) q <= '0;
            else     q <= d;
        end

        assign rs_out[k*WORDSIZE +: WORDSIZE] = q;
    end

    assign dbg_d = rd_word(debug_addr);

    always_ff @(posedge clk) begin
        if (rst) debug_out <= '0;
        else     debug_out <= dbg_d;
    end
endmodule

// File: tb/tb_regfile_multiport.sv
// Randomised self-checking bench for regfile_multiport against an array/counter reference model.
module tb_regfile_multiport;
    localparam int W     = 64;
    localparam int SIZE  = 32;
    localparam int NREAD = 2;
    localparam int AW    = $clog2(SIZE);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREAD*AW-1:0]  rs_addr = '0;
    logic [NREAD*W-1:0]   rs_out;
    logic [AW-1:0]        rd_addr = '0;
    logic [W-1:0]         rd_in = '0;
    logic                 we = 1'b0;
    logic                 clear_req = 1'b0;
    logic                 busy;
    logic [AW-1:0]        debug_addr = '0;
    logic [W-1:0]         debug_out;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: contents, remaining clear cycles, next clear index, expected outputs.
    logic [W-1:0] mem_m [SIZE];
    int           clr_left = SIZE;
    int           clr_idx  = 0;
    logic [W-1:0] exp_rs [NREAD];
    logic [W-1:0] exp_dbg;

    regfile_multiport #(.WORDSIZE(W), .SIZE(SIZE), .NREAD(NREAD)) dut (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_out(rs_out),
        .rd_addr(rd_addr), .rd_in(rd_in), .we(we), .clear_req(clear_req),
        .busy(busy), .debug_addr(debug_addr), .debug_out(debug_out)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mread(input int a, input bit bsy, input bit wr);
        if (bsy || a == 0 || a >= SIZE) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wr && a == int'(rd_addr)) return rd_in;
`endif
        return mem_m[a];
    endfunction

    // One clock edge: advance the model using the inputs the DUT samples, then settle.
    task automatic tick();
        bit bsy, wr;
        @(posedge clk);
        if (rst) begin
            clr_left = SIZE;
            clr_idx  = 0;
            for (int k = 0; k < NREAD; k++) exp_rs[k] = '0;
            exp_dbg = '0;
        end else begin
            bsy = (clr_left > 0);
            wr  = !bsy && we && !clear_req && rd_addr != 0 && int'(rd_addr) < SIZE;
            for (int k = 0; k < NREAD; k++) exp_rs[k] = mread(int'(rs_addr[k*AW +: AW]), bsy, wr);
            exp_dbg = mread(int'(debug_addr), bsy, wr);
            if (bsy) begin
                mem_m[clr_idx] = '0;
                clr_idx++;
                clr_left--;
            end else if (clear_req) begin
                clr_left = SIZE;
                clr_idx  = 0;
            end else if (wr) begin
                mem_m[rd_addr] = rd_in;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        int cnt = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (rs_out !== '0 || debug_out !== '0 || busy !== 1'b1)
            $display("FAIL reset_state rs_out=%h dbg=%h busy=%b want 0/0/1", rs_out, debug_out, busy);
        else n_pass++;
        while (busy === 1'b1 && cnt < 40) begin
            rs_addr    = AW*NREAD'($urandom);
            debug_addr = AW'($urandom);
            tick();
            cnt++;
            if (cnt < SIZE) begin
                n_checks++;
                if (rs_out !== '0 || debug_out !== '0)
                    $display("FAIL reset_reads cyc=%0d rs_out=%h dbg=%h want 0", cnt, rs_out, debug_out);
                else n_pass++;
            end
        end
        n_checks++;
        if (cnt != SIZE || busy !== 1'b0)
            $display("FAIL reset_busy_len got=%0d busy=%b want %0d/0", cnt, busy, SIZE);
        else n_pass++;
    endtask

    task automatic test_write_read();
        we = 1'b1; rd_addr = 4; rd_in = 64'h0000_0000_5F11_E01A;
        tick();
        we = 1'b0;
        rs_addr[0 +: AW] = 4; rs_addr[AW +: AW] = 0; debug_addr = 4;
        tick();
        n_checks++;
        if (rs_out[0 +: W] !== 64'h0000_0000_5F11_E01A || rs_out[0 +: W] !== exp_rs[0])
            $display("FAIL write_read got=%h want=%h", rs_out[0 +: W], 64'h0000_0000_5F11_E01A);
        else n_pass++;
        n_checks++;
        if (debug_out !== 64'h0000_0000_5F11_E01A)
            $display("FAIL write_read_dbg got=%h want=%h", debug_out, 64'h0000_0000_5F11_E01A);
        else n_pass++;
    endtask

    task automatic test_hazard();
        logic [W-1:0] want;
`ifdef REGFILE_BYPASS_EN
        want = 64'h2;
`else
        want = 64'h1;
`endif
        we = 1'b1; rd_addr = 7; rd_in = 64'h1;
        tick();
        rd_in = 64'h2;
        rs_addr[0 +: AW] = 7; rs_addr[AW +: AW] = 7; debug_addr = 7;
        tick();
        we = 1'b0;
        for (int k = 0; k < NREAD; k++) begin
            n_checks++;
            if (rs_out[k*W +: W] !== want || rs_out[k*W +: W] !== exp_rs[k])
                $display("FAIL hazard port%0d got=%h want=%h", k, rs_out[k*W +: W], want);
            else n_pass++;
        end
        n_checks++;
        if (debug_out !== want)
            $display("FAIL hazard_dbg got=%h want=%h", debug_out, want);
        else n_pass++;
        tick();
        n_checks++;
        if (rs_out[0 +: W] !== 64'h2)
            $display("FAIL hazard_after got=%h want=%h", rs_out[0 +: W], 64'h2);
        else n_pass++;
    endtask

    task automatic test_zero_reg();
        we = 1'b1; rd_addr = 0; rd_in = '1;
        rs_addr = '0; debug_addr = 0;
        tick();
        we = 1'b0;
        tick();
        n_checks++;
        if (rs_out !== '0 || debug_out !== '0)
            $display("FAIL zero_reg rs_out=%h dbg=%h want 0", rs_out, debug_out);
        else n_pass++;
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 300; i++) begin
            we         = ($urandom_range(0, 2) != 0);
            rd_addr    = AW'($urandom);
            rd_in      = {$urandom, $urandom};
            rs_addr    = AW*NREAD'($urandom);
            debug_addr = AW'($urandom);
            tick();
            for (int k = 0; k < NREAD; k++) begin
                n_checks++;
                if (rs_out[k*W +: W] !== exp_rs[k]) begin
                    errs++;
                    if (errs < 10) $display("FAIL random port%0d i=%0d got=%h want=%h", k, i, rs_out[k*W +: W], exp_rs[k]);
                end else n_pass++;
            end
            n_checks++;
            if (debug_out !== exp_dbg) begin
                errs++;
                if (errs < 10) $display("FAIL random_dbg i=%0d got=%h want=%h", i, debug_out, exp_dbg);
            end else n_pass++;
        end
        we = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        we = 1'b0;
        for (int a = 0; a < SIZE; a++) begin
            rs_addr[0 +: AW] = AW'(a); rs_addr[AW +: AW] = AW'(SIZE - 1 - a); debug_addr = AW'(a);
            tick();
            n_checks++;
            if (rs_out !== '0 || debug_out !== '0 || rs_out[0 +: W] !== exp_rs[0])
                $display("FAIL %s addr=%0d rs_out=%h dbg=%h want 0", tag, a, rs_out, debug_out);
            else n_pass++;
        end
    endtask

    task automatic test_clear();
        int cnt = 0;
        we = 1'b1;
        for (int a = 1; a < SIZE; a++) begin
            rd_addr = AW'(a); rd_in = W'(a);
            tick();
        end
        we = 1'b0; rs_addr[0 +: AW] = 17; debug_addr = 31;
        tick();
        n_checks++;
        if (rs_out[0 +: W] !== 64'd17 || debug_out !== 64'd31)
            $display("FAIL fill got=%h/%h want 17/31", rs_out[0 +: W], debug_out);
        else n_pass++;
        clear_req = 1'b1; we = 1'b1; rd_addr = 9; rd_in = '1;
        tick();
        clear_req = 1'b0;
        while (busy === 1'b1 && cnt < 40) begin
            clear_req = (cnt == 5);
            rd_addr   = AW'($urandom_range(1, SIZE - 1));
            rd_in     = {$urandom, $urandom};
            tick();
            cnt++;
        end
        clear_req = 1'b0; we = 1'b0;
        n_checks++;
        if (cnt != SIZE || busy !== 1'b0)
            $display("FAIL clear_busy_len got=%0d busy=%b want %0d/0", cnt, busy, SIZE);
        else n_pass++;
        check_all_zero("clear_contents");
    endtask

    task automatic test_reset_mid_clear();
        int cnt = 0;
        we = 1'b1;
        for (int a = 1; a < SIZE; a++) begin
            rd_addr = AW'(a); rd_in = {$urandom, $urandom};
            tick();
        end
        we = 1'b0;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        while (busy === 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        n_checks++;
        if (cnt != SIZE || busy !== 1'b0)
            $display("FAIL midclear_busy_len got=%0d busy=%b want %0d/0", cnt, busy, SIZE);
        else n_pass++;
        check_all_zero("midclear_contents");
    endtask

    initial begin
        for (int a = 0; a < SIZE; a++) mem_m[a] = '0;
        test_reset();
        test_write_read();
        test_hazard();
        test_zero_reg();
        test_random();
        test_clear();
        test_random();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
